// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing helpers for the PISO serializer and its companion receiver.
package piso_pkg;

  // Frame state: waiting for a word, or shifting one out.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Bit-counter width needed to count 0..width-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Loadable up-counter with clear, enable and a terminal-count flag at WIDTH-1.
// Priority: reset > clear > load > enable.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_clr,
  input  logic                        i_load,
  input  logic [cnt_width(WIDTH)-1:0] i_load_val,
  input  logic                        i_en,
  output logic [cnt_width(WIDTH)-1:0] o_cnt,
  output logic                        o_tc
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: clear wins over load, load wins over increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and drives it out one bit per shift_en tick. The last-bit tick doubles as an
// accept slot so back-to-back words leave no idle gap on the line.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  piso_state_t      r_state;
  piso_state_t      w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;
  logic             w_ready_raw;
  logic             w_accept;
  logic             w_tick;
  logic             w_advance;
  logic             w_end_idle;
  logic             w_out_bit;

  assign w_tick     = (r_state == SHIFT) && shift_en;
  assign w_accept   = load_valid && load_ready;
  assign w_advance  = w_tick && !w_tc;
  assign w_end_idle = w_tick && w_tc && !load_valid;

  // Next-state and accept-window decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ready_raw = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready_raw = 1'b1;
        if (load_valid) begin
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (shift_en && w_tc) begin
          w_ready_raw = 1'b1;
          if (load_valid) begin
            w_state_nxt = SHIFT;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ready_raw = 1'b0;
      end
    endcase
  end

  // Ready is masked by reset so nothing is accepted on a reset edge.
  always_comb begin
    if (reset) begin
      load_ready = 1'b0;
    end else begin
      load_ready = w_ready_raw;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift register: load on accept, otherwise shift toward the output end on each tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      r_shreg <= load_data;
    end else if (w_tick) begin
      if (LSB_FIRST) begin
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end else begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      end
    end else begin
      r_shreg <= r_shreg;
    end
  end

  // Bit position within the frame; cleared on a new word and when the frame ends.
  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_accept || w_end_idle),
    .i_load     (1'b0),
    .i_load_val ({CNT_W{1'b0}}),
    .i_en       (w_advance),
    .o_cnt      (w_cnt),
    .o_tc       (w_tc)
  );

  // Output-end bit of the shift register, selected by bit order.
  always_comb begin
    if (LSB_FIRST) begin
      w_out_bit = r_shreg[0];
    end else begin
      w_out_bit = r_shreg[WIDTH-1];
    end
  end

  // Serial line outputs, all derived from registered state; line is 0 when idle.
  always_comb begin
    if (r_state == SHIFT) begin
      ser_out   = w_out_bit;
      ser_valid = 1'b1;
      ser_last  = (w_cnt == CNT_W'(WIDTH - 1));
    end else begin
      ser_out   = 1'b0;
      ser_valid = 1'b0;
      ser_last  = 1'b0;
    end
  end

  assign busy = ser_valid;

endmodule
